// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the scratch-SRAM round-robin arbiter.
package sram_arb_pkg;

  localparam int STATS_CNT_WIDTH = 16;
  localparam int DEF_DATA_WIDTH  = 128;
  localparam int DEF_ADDR_WIDTH  = 10;
  localparam int MAX_REQ         = 8;

  // Width of a requester index / round-robin pointer; never narrower than one bit.
  function automatic int req_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int REQ_IDX_WIDTH = req_idx_width(MAX_REQ);

  typedef struct packed {
    logic                      we;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } sram_cmd_t;

endpackage

// File: rtl/sram_arbiter_rr.sv
// Round-robin grant: first requester at or after the pointer (wrapping) wins;
// the pointer moves just past the winner on every grant.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = req_idx_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               grant_valid
);

  logic [IW-1:0] rr_ptr;
  int            cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    if (!rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = (int'(rr_ptr) + k) % NUM_REQ;
        if (!grant_valid && req[cand]) begin
          grant[cand] = 1'b1;
          grant_idx   = IW'(cand);
          grant_valid = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one scratch SRAM (separate read/write ports) between NUM_REQ masters.
// Optional per-requester grant counters are enabled with SRAM_ARB_STATS_EN.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          sram_wen,
  output logic [ADDR_WIDTH-1:0]         sram_wadr,
  output logic [DATA_WIDTH-1:0]         sram_wdata,
  output logic                          sram_ren,
  output logic [ADDR_WIDTH-1:0]         sram_radr,
  input  logic [DATA_WIDTH-1:0]         sram_rdata
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_CNT_WIDTH-1:0] grant_cnt
`endif
);

  localparam int IW = req_idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]    grant;
  logic [IW-1:0]         grant_idx;
  logic                  grant_valid;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [IW-1:0]         iss_tag;
  logic                  rsp_tag_valid;
  logic [IW-1:0]         rsp_tag;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk        (clk),
    .rst        (rst),
    .req        (req_valid),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  assign req_ready = grant;

  // One-hot grant makes an AND-OR mux safe for any NUM_REQ, power of two or not.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_we    = sel_we | req_we[i];
        sel_addr  = sel_addr | req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = sel_wdata | req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sram_wen   <= 1'b0;
      sram_ren   <= 1'b0;
      sram_wadr  <= '0;
      sram_wdata <= '0;
      sram_radr  <= '0;
      iss_tag    <= '0;
    end else begin
      sram_wen <= grant_valid & sel_we;
      sram_ren <= grant_valid & ~sel_we;
      if (grant_valid && sel_we) begin
        sram_wadr  <= sel_addr;
        sram_wdata <= sel_wdata;
      end
      if (grant_valid && !sel_we) begin
        sram_radr <= sel_addr;
        iss_tag   <= grant_idx;
      end
    end
  end

  // The read tag trails the issue stage by one cycle to line up with sram_rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_tag_valid <= 1'b0;
      rsp_tag       <= '0;
    end else begin
      rsp_tag_valid <= sram_ren;
      rsp_tag       <= iss_tag;
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = rsp_tag_valid && (rsp_tag == IW'(i));
    end
  end

  assign rsp_data = sram_rdata;

`ifdef SRAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst) begin
        grant_cnt[i*STATS_CNT_WIDTH +: STATS_CNT_WIDTH] <= '0;
      end else if (grant[i] && (grant_cnt[i*STATS_CNT_WIDTH +: STATS_CNT_WIDTH] != '1)) begin
        grant_cnt[i*STATS_CNT_WIDTH +: STATS_CNT_WIDTH] <=
          grant_cnt[i*STATS_CNT_WIDTH +: STATS_CNT_WIDTH] + 1'b1;
      end
    end
  end
`endif

endmodule
